// File: rtl/matvec_stream_engine.sv
// Streaming matrix-vector engine: loads A (row beats) and B over valid/ready,
// runs a weight-stationary MAC chain, and drains C one element per beat.
module matvec_stream_engine #(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned COLS   = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned ACCW   = 2*DW + $clog2(COLS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  accum,
  input  logic                                  abort,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [COLS*DW-1:0]                    in_data,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [ACCW-1:0]                       res_data,
  output logic [(ROWS>1 ? $clog2(ROWS) : 1)-1:0] res_idx,
  output logic                                  res_last,
  output logic                                  busy,
  output logic                                  done,
  output logic [1:0]                            state_o
);

  localparam int unsigned IW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned JW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned LW = $clog2(ROWS + 1);
  localparam int unsigned KW = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMPUTE = 2'd2, DRAIN = 2'd3} state_t;

  state_t                              state;
  logic [ROWS-1:0][COLS-1:0][DW-1:0]   a_buf;
  logic [COLS-1:0][DW-1:0]             b_buf;
  logic [ROWS-1:0][DW-1:0]             pipe_b;
  logic [ROWS-1:0][JW-1:0]             pipe_j;
  logic [ROWS-1:0]                     pipe_en;
  logic [ROWS-1:0][ACCW-1:0]           acc;
  logic [ROWS-1:0][ACCW-1:0]           acc_nxt;
  logic [LW-1:0]                       load_cnt;
  logic [KW-1:0]                       k_cnt;

  assign state_o = state;

  // Full-precision product, sign- or zero-extended to the accumulator width
  function automatic logic [ACCW-1:0] mac_term(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    if (SIGNED != 0) begin
      p = (2*DW)'($signed(a)) * (2*DW)'($signed(b));
      return ACCW'($signed(p));
    end
    p = (2*DW)'(a) * (2*DW)'(b);
    return ACCW'(p);
  endfunction

  // MAC i sees B[j] and its enable i cycles after MAC 0 did
  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < ROWS; i++) begin
      if (state == COMPUTE && pipe_en[i])
        acc_nxt[i] = acc[i] + mac_term(a_buf[i][pipe_j[i]], pipe_b[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
      res_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      a_buf     <= '0;
      b_buf     <= '0;
      pipe_b    <= '0;
      pipe_j    <= '0;
      pipe_en   <= '0;
      acc       <= '0;
      load_cnt  <= '0;
      k_cnt     <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state     <= IDLE;
        in_ready  <= 1'b0;
        res_valid <= 1'b0;
        res_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state    <= LOAD;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              load_cnt <= '0;
              if (!accum) acc <= '0;
            end
          end
          LOAD: begin
            if (in_valid) begin
              if (load_cnt == LW'(ROWS)) begin
                // B beat: prime stage 0 with column 0 and start computing
                b_buf     <= in_data;
                pipe_b[0] <= in_data[DW-1:0];
                pipe_j[0] <= '0;
                pipe_en   <= ROWS'(1);
                k_cnt     <= '0;
                in_ready  <= 1'b0;
                state     <= COMPUTE;
              end else begin
                a_buf[IW'(load_cnt)] <= in_data;
                load_cnt             <= load_cnt + LW'(1);
              end
            end
          end
          COMPUTE: begin
            acc <= acc_nxt;
            for (int i = 1; i < ROWS; i++) begin
              pipe_b[i]  <= pipe_b[i-1];
              pipe_j[i]  <= pipe_j[i-1];
              pipe_en[i] <= pipe_en[i-1];
            end
            if (pipe_en[0] && pipe_j[0] != JW'(COLS - 1)) begin
              pipe_en[0] <= 1'b1;
              pipe_j[0]  <= pipe_j[0] + JW'(1);
              pipe_b[0]  <= b_buf[pipe_j[0] + JW'(1)];
            end else begin
              pipe_en[0] <= 1'b0;
            end
            k_cnt <= k_cnt + KW'(1);
            if (k_cnt == KW'(ROWS + COLS - 2)) begin
              state     <= DRAIN;
              res_valid <= 1'b1;
              res_idx   <= '0;
              res_data  <= acc_nxt[0];
              res_last  <= (ROWS == 1);
            end
          end
          DRAIN: begin
            if (res_ready) begin
              if (res_last) begin
                state     <= IDLE;
                res_valid <= 1'b0;
                res_last  <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else begin
                res_idx  <= res_idx + IW'(1);
                res_data <= acc[res_idx + IW'(1)];
                res_last <= ((res_idx + IW'(1)) == IW'(ROWS - 1));
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
